// File: rtl/dmem_bank_if.sv
// Request/response bus between the MEM stage and the data memory bank.
// The master (CPU side) issues load/store requests and accepts responses;
// the slave (memory side) accepts requests and returns one response per request.
interface dmem_bank_if #(
  parameter int AW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_bank.sv
// Byte-addressable data memory for the MEM stage.
// Clears itself word-by-word after reset, then serves load/store requests
// with a one-entry registered response buffer, plus a debug read port.
// Optional feature: define DMEM_ALIGN_CHECK_EN to flag misaligned halfword
// and word accesses as errors; without it, low address bits are ignored.
module dmem_bank #(
  parameter int DEPTH = 64,
  parameter int AW    = 32,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  dmem_bank_if.slave    bus,
  input  logic          stall,
  output logic          init_done,
  input  logic          dbg_en,
  input  logic [IW-1:0] dbg_addr,
  output logic [31:0]   dbg_rdata,
  output logic          dbg_valid
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] count_q, count_d;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          range_err, size_err, align_err, any_err;
  logic [IW-1:0] word_idx;
  logic [1:0]    byte_lane;
  logic          half_lane;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   rd_word, rd_shift, load_data;
  logic [15:0]   rd_half;

  assign word_idx  = bus.req_addr[IW+1:2];
  assign byte_lane = bus.req_addr[1:0];
  assign half_lane = bus.req_addr[1];

  assign range_err = |bus.req_addr[AW-1:IW+2];
  assign size_err  = (bus.req_size == 2'b11);
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign any_err = range_err | size_err | align_err;

  assign init_done     = (state_q == RUN);
  assign bus.req_ready = (state_q == RUN) & ~stall & ~dbg_en & (~bus.rsp_valid | bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;

  // State and clear-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state: walk the counter through every word, then enter RUN.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      CLEAR: begin
        count_d = count_q + IW'(1);
        if (count_q == LAST_IDX) begin
          state_d = RUN;
          count_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Lane selection for stores and right-justified extraction for loads.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = '0;
    rd_word   = mem[word_idx];
    rd_shift  = rd_word >> {byte_lane, 3'b000};
    rd_half   = half_lane ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (bus.req_size)
      2'b00: begin
        byte_en   = 4'b0001 << byte_lane;
        wdata_rep = {4{bus.req_wdata[7:0]}};
        load_data = bus.req_unsigned ? {24'b0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      2'b01: begin
        byte_en   = half_lane ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
        load_data = bus.req_unsigned ? {16'b0, rd_half}
                                     : {{16{rd_half[15]}}, rd_half};
      end
      2'b10: begin
        byte_en   = 4'b1111;
        wdata_rep = bus.req_wdata;
        load_data = rd_word;
      end
      default: ;
    endcase
  end

  // Memory array: zero-fill during CLEAR, lane-masked stores in RUN.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[count_q] <= '0;
    end else if (accept && bus.req_we && !any_err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // One-entry response buffer: loaded on acceptance, drained by rsp_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_err   <= any_err;
      bus.rsp_rdata <= (any_err || bus.req_we) ? 32'h0 : load_data;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

  // Debug read port: one-cycle registered read while debug mode is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rdata <= '0;
      dbg_valid <= 1'b0;
    end else if (dbg_en && (state_q == RUN)) begin
      dbg_rdata <= mem[dbg_addr];
      dbg_valid <= 1'b1;
    end else begin
      dbg_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_bank.sv
// Directed testbench for dmem_bank with hand-computed expected values.
module tb_dmem_bank;
  localparam int DEPTH = 64;
  localparam int IW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          stall;
  logic          init_done;
  logic          dbg_en;
  logic [IW-1:0] dbg_addr;
  logic [31:0]   dbg_rdata;
  logic          dbg_valid;

  int vectors;
  int miscompares;

  dmem_bank_if #(.AW(32)) bus ();

  dmem_bank #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stall     (stall),
    .init_done (init_done),
    .dbg_en    (dbg_en),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .dbg_valid (dbg_valid)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic checkResp(input string tag, input logic [31:0] exp_data, input logic exp_err);
    checkOutput({tag, "_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
    checkOutput({tag, "_data"}, bus.rsp_rdata, exp_data);
    checkOutput({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
  endtask

  // Present one request and return #1 after the edge that accepted it.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Release reset and count cycles until req_ready rises.
  task automatic releaseReset(input string tag);
    int cnt;
    rst = 1'b0;
    cnt = 0;
    while (!bus.req_ready && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput({tag, "_clear_cycles"}, cnt, DEPTH);
    checkOutput({tag, "_init_done"}, {31'b0, init_done}, 32'd1);
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    stall            = 1'b0;
    dbg_en           = 1'b0;
    dbg_addr         = '0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("rst_dbg_valid", {31'b0, dbg_valid}, 32'd0);
    releaseReset("boot");

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    checkResp("ld_word5", 32'h0, 1'b0);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABC);
    checkResp("st_word10", 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    checkResp("ld_b12_s", 32'hFFFFFF99, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    checkResp("ld_b12_u", 32'h00000099, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    checkResp("ld_h10_s", 32'hFFFFAABC, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checkResp("ld_h12_u", 32'h00008899, 1'b0);

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF7F);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checkResp("ld_w20_after_byte", 32'h00007F00, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checkResp("ld_w20_after_half", 32'hBEEF7F00, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    checkResp("ld_b23_s", 32'hFFFFFFBE, 1'b0);

    // Back-to-back loads, one accepted per cycle.
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    @(posedge clk); #1;
    checkResp("b2b_0", 32'h8899AABC, 1'b0);
    checkOutput("b2b_0_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_addr = 32'h20;
    @(posedge clk); #1;
    checkResp("b2b_1", 32'hBEEF7F00, 1'b0);
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b1;
    bus.req_addr     = 32'h11;
    @(posedge clk); #1;
    checkResp("b2b_2", 32'h000000AA, 1'b0);
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b_drain", {31'b0, bus.rsp_valid}, 32'd0);

    // Backpressure and stall.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkResp("bp_pending", 32'h8899AABC, 1'b0);
    checkOutput("bp_ready_low", {31'b0, bus.req_ready}, 32'd0);
    bus.req_valid    = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h20;
    @(posedge clk); #1;
    checkResp("bp_hold", 32'h8899AABC, 1'b0);
    stall = 1'b1;
    @(posedge clk); #1;
    checkResp("stall_hold", 32'h8899AABC, 1'b0);
    bus.rsp_ready = 1'b1;
    #1;
    checkOutput("stall_ready_low", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk); #1;
    checkOutput("stall_drain", {31'b0, bus.rsp_valid}, 32'd0);
    stall = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkResp("release_next", 32'hBEEF7F00, 1'b0);

    // Error cases.
    applyStimulus(1'b0, 2'b10, 1'b0, DEPTH * 4, 32'h0);
    checkResp("range_err", 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    checkResp("size_err", 32'h0, 1'b1);
    applyStimulus(1'b1, 2'b10, 1'b0, DEPTH * 4 + 32'h10, 32'hDEADBEEF);
    checkResp("range_st_err", 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkResp("range_st_nowrite", 32'h8899AABC, 1'b0);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h02, 32'hCAFEF00D);
`ifdef DMEM_ALIGN_CHECK_EN
    checkResp("misalign_st", 32'h0, 1'b1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    checkResp("misalign_word0", 32'h0, 1'b0);
`else
    checkResp("misalign_st", 32'h0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
    checkResp("misalign_word0", 32'hCAFEF00D, 1'b0);
`endif

    // Debug read port.
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    dbg_en   = 1'b1;
    dbg_addr = 6'd4;
    @(posedge clk); #1;
    checkOutput("dbg_valid", {31'b0, dbg_valid}, 32'd1);
    checkOutput("dbg_data4", dbg_rdata, 32'h12345678);
    checkOutput("dbg_ready_low", {31'b0, bus.req_ready}, 32'd0);
    dbg_addr = 6'd8;
    @(posedge clk); #1;
    checkOutput("dbg_data8", dbg_rdata, 32'hBEEF7F00);
    dbg_en = 1'b0;
    @(posedge clk); #1;
    checkOutput("dbg_off_valid", {31'b0, dbg_valid}, 32'd0);
    checkOutput("dbg_off_hold", dbg_rdata, 32'hBEEF7F00);

    // Mid-operation reset with a pending response.
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checkResp("pre_rst_pending", 32'hBEEF7F00, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("mid_rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    checkOutput("mid_rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("mid_rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    checkOutput("mid_rst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("mid_rst_dbg_valid", {31'b0, dbg_valid}, 32'd0);
    checkOutput("mid_rst_dbg_rdata", dbg_rdata, 32'h0);
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    releaseReset("reboot");
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkResp("reboot_cleared", 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bank.md
# dmem_bank

Parametrised, byte-addressable data memory for the MEM stage of the pipelined CPU. It accepts load/store requests over a valid/ready handshake and returns registered, right-justified, sign- or zero-extended load data, with an error flag for bad accesses. After reset it clears itself word-by-word, and it offers a debug read port for the UART debug unit.

## Interface
- DEPTH, 64, number of 32-bit words; power of two, at least 4
- AW, 32, byte-address width of `req_addr`
- IW, $clog2(DEPTH), word-index width of `dbg_addr`
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  load result; 0 for stores and errored accesses
- rsp_err  out  1  access error (range, alignment or size)
- stall  in  1  pipeline freeze
- init_done  out  1  clear sequence complete
- dbg_en  in  1  debug read mode
- dbg_addr  in  IW  debug word index
- dbg_rdata  out  32  debug read data
- dbg_valid  out  1  `dbg_rdata` is valid

## Operation
- The FSM has two states, CLEAR and RUN. Reset enters CLEAR with counter=0.
- In CLEAR, the block writes 0 to `mem[counter]` on each cycle and increments the counter. After `counter==DEPTH-1` it moves to RUN and sets `init_done=1`.
- `req_ready` = RUN & !stall & !dbg_en & (!rsp_valid | rsp_ready).
- A request is accepted when `req_valid` and `req_ready` are both 1.
- Addressing: word index = `req_addr[IW+1:2]`, byte lane = `req_addr[1:0]`, half lane = `req_addr[1]`.
- Range error: `req_addr[AW-1:IW+2]` is nonzero.
- Size error: `req_size==11`.
- Any error suppresses the write. The response carries `rsp_err=1` and `rsp_rdata=0`.
- Stores write only the selected lanes: byte lane, half lane, or the full word.
- Loads extract the selected lane into bits [7:0] or [15:0] of `rsp_rdata`. The upper bits are filled with zeros or the lane's MSB, according to `req_unsigned`.
- Every accepted request, store or load, produces exactly one response.
- Output buffer: one entry. It is loaded on acceptance and cleared by `rsp_ready` when there is no new acceptance. A response hand-off and a new acceptance in the same cycle replace the entry, giving one request per cycle throughput.
- `stall=1` blocks acceptance and holds `rsp_valid`/`rsp_rdata`/`rsp_err` unchanged. `rsp_ready` is still honoured.
- Debug: when `dbg_en=1` in RUN, `dbg_rdata <= mem[dbg_addr]` every cycle and `dbg_valid <= 1`. Otherwise `dbg_valid <= 0` and `dbg_rdata` holds its value. A pending response is unaffected by debug mode.

## Timing
- Reset values: `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `init_done=0`, `dbg_valid=0`, `dbg_rdata=0`, state=CLEAR.
- The clear sequence takes DEPTH cycles after `rst` falls. `req_ready` first rises on cycle DEPTH.
- Load latency is 1: a request accepted at edge N gives `rsp_valid=1` after edge N.
- A store takes effect at the acceptance edge, so a load accepted on the next cycle returns the new data.
- Asserting `rst` mid-operation aborts everything immediately: the pending response is lost and CLEAR restarts.
- Debug latency is 1 cycle.

## Configuration
- DMEM_ALIGN_CHECK_EN defined: a halfword with `req_addr[0]=1` or a word with `req_addr[1:0]!=0` raises `rsp_err` and suppresses the write.
- DMEM_ALIGN_CHECK_EN undefined: no alignment error. A halfword ignores `req_addr[0]` and a word ignores `req_addr[1:0]`.

## Test plan
- Reset, then count cycles until `req_ready` rises → exactly DEPTH cycles. A load from word 5 returns 0 with `rsp_err=0`.
- Store word 0x8899AABC at address 0x10. Load the byte at 0x12 signed → 0xFFFFFF99. Load the same byte unsigned → 0x00000099. Load the halfword at 0x10 signed → 0xFFFFAABC.
- Store byte 0x7F at 0x21, then load the word at 0x20 → 0x00007F00. Loads issued back-to-back while `rsp_ready` is held at 1 → one response per cycle, in order.
- Hold `rsp_ready=0` with a response pending → `req_ready=0` and the response stays stable. Raise `stall` → outputs frozen. Release both → the response completes.
- Load from address DEPTH*4 → `rsp_err=1`, `rsp_rdata=0`. With DMEM_ALIGN_CHECK_EN, store a word at 0x02 → `rsp_err=1` and memory unchanged. Without the macro, the same store writes word 0.
- Set `dbg_en=1`, `dbg_addr=4` after storing 0x12345678 at 0x10 → `dbg_valid=1` and `dbg_rdata=0x12345678` one cycle later, with `req_ready=0`. Assert `rst` mid-test → all outputs return to reset values.
